// File: rtl/sram_bus_slave.sv
// Bus slave that turns each 8-bit bus transaction into one timed cycle on an async SRAM.
// Every output is a register; the SRAM strobes are produced from the next state.
module sram_bus_slave #(
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  input  logic        i_cs,
  input  logic        i_we,
  output logic        o_ack,
  output logic [15:0] o_sram_addr,
  input  logic [7:0]  i_sram_dat,
  output logic [7:0]  o_sram_dat,
  output logic        o_sram_dat_oe,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] wait_cnt_r;
  logic       we_r;
  logic       start_s;
  logic       last_access_s;
  logic       we_next_s;
  logic       ce_n_s;
  logic       oe_n_s;
  logic       we_n_s;
  logic       dat_oe_s;
  logic       ack_s;

  assign start_s       = (state_r == ST_IDLE) && i_cs;
  assign last_access_s = (wait_cnt_r == 4'd0);
  // The direction of the cycle being entered: fresh from the bus when starting, latched otherwise.
  assign we_next_s     = (state_r == ST_IDLE) ? i_we : we_r;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; dropping cs before ACK aborts straight into bus turnaround
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:    state_next_s = i_cs ? ST_SETUP : ST_IDLE;
      ST_SETUP:   state_next_s = i_cs ? ST_ACCESS : ST_RECOVER;
      ST_ACCESS: begin
        if (!i_cs) begin
          state_next_s = ST_RECOVER;
        end else if (last_access_s) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_ACK:     state_next_s = ST_RECOVER;
      ST_RECOVER: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // SRAM strobe values for the state about to be entered
  always_comb begin
    ce_n_s   = 1'b1;
    oe_n_s   = 1'b1;
    we_n_s   = 1'b1;
    dat_oe_s = 1'b0;
    ack_s    = 1'b0;
    case (state_next_s)
      ST_SETUP: begin
        ce_n_s = 1'b0;
        if (we_next_s) begin
          dat_oe_s = 1'b1;
        end else begin
          oe_n_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        ce_n_s = 1'b0;
        if (we_next_s) begin
          dat_oe_s = 1'b1;
          we_n_s   = 1'b0;
        end else begin
          oe_n_s = 1'b0;
        end
      end
      ST_ACK: begin
        ce_n_s = 1'b0;
        ack_s  = 1'b1;
        if (we_next_s) begin
          dat_oe_s = 1'b1;
        end else begin
          dat_oe_s = 1'b0;
        end
      end
      default: begin
        ce_n_s = 1'b1;
      end
    endcase
  end

  // Transaction latch, wait-state counter and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_cnt_r    <= 4'd0;
      we_r          <= 1'b0;
      o_dat         <= 8'h00;
      o_ack         <= 1'b0;
      o_sram_addr   <= 16'h0000;
      o_sram_dat    <= 8'h00;
      o_sram_dat_oe <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
    end else begin
      o_ack         <= ack_s;
      o_sram_dat_oe <= dat_oe_s;
      o_sram_ce_n   <= ce_n_s;
      o_sram_oe_n   <= oe_n_s;
      o_sram_we_n   <= we_n_s;
      if (start_s) begin
        we_r        <= i_we;
        o_sram_addr <= i_addr;
        if (i_we) begin
          o_sram_dat <= i_dat;
        end
      end
      if (state_r == ST_SETUP) begin
        wait_cnt_r <= WAIT_LOAD;
      end else if ((state_r == ST_ACCESS) && !last_access_s) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end
      if ((state_r == ST_ACCESS) && i_cs && last_access_s && !we_r) begin
        o_dat <= i_sram_dat;
      end
    end
  end

endmodule
